// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : morse_pkg
// Brief   : Shared FSM encoding, ASCII ranges, unit counts and code record.
// Revision: 1.0 - initial release
// ============================================================================
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_GAP   = 2'd3
  } morse_state_e;

  // Pattern is left-aligned: element 0 sits in bit 4, 1 = dash.
  typedef struct packed {
    logic       supported;
    logic       is_space;
    logic [2:0] length;
    logic [4:0] pattern;
  } morse_code_t;

  localparam int unsigned c_unit_cycles_default = 25_000_000;

  localparam logic [7:0] c_ascii_space   = 8'h20;
  localparam logic [7:0] c_ascii_digit_0 = 8'h30;
  localparam logic [7:0] c_ascii_digit_9 = 8'h39;
  localparam logic [7:0] c_ascii_upper_a = 8'h41;
  localparam logic [7:0] c_ascii_upper_z = 8'h5A;
  localparam logic [7:0] c_ascii_lower_a = 8'h61;
  localparam logic [7:0] c_ascii_lower_z = 8'h7A;
  localparam logic [7:0] c_case_fold     = 8'h20;

  localparam logic [2:0] c_dot_units   = 3'd1;
  localparam logic [2:0] c_dash_units  = 3'd3;
  localparam logic [2:0] c_space_units = 3'd1;
  localparam logic [2:0] c_gap_units   = 3'd3;
  localparam logic [2:0] c_word_units  = 3'd4;

  function automatic logic [2:0] element_units(input logic is_dash);
    return is_dash ? c_dash_units : c_dot_units;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_lut.sv
`default_nettype none
// ============================================================================
// Module  : morse_lut
// Brief   : Combinational ASCII -> Morse code lookup (ITU). Digits are
//           included when MORSE_DIGITS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] i_letter,
  output logic       o_supported,
  output logic       o_is_space,
  output logic [2:0] o_length,
  output logic [4:0] o_pattern
);

  logic [7:0]  w_upper;
  morse_code_t w_code;

  always_comb begin
    w_upper = i_letter;
    if (i_letter >= c_ascii_lower_a && i_letter <= c_ascii_lower_z) begin
      w_upper = i_letter - c_case_fold;
    end

    w_code = '0;
    if (w_upper == c_ascii_space) begin
      w_code.supported = 1'b1;
      w_code.is_space  = 1'b1;
    end else if (w_upper >= c_ascii_upper_a && w_upper <= c_ascii_upper_z) begin
      w_code.supported = 1'b1;
      case (w_upper)
        8'h41:   {w_code.length, w_code.pattern} = {3'd2, 5'b01000}; // A .-
        8'h42:   {w_code.length, w_code.pattern} = {3'd4, 5'b10000}; // B -...
        8'h43:   {w_code.length, w_code.pattern} = {3'd4, 5'b10100}; // C -.-.
        8'h44:   {w_code.length, w_code.pattern} = {3'd3, 5'b10000}; // D -..
        8'h45:   {w_code.length, w_code.pattern} = {3'd1, 5'b00000}; // E .
        8'h46:   {w_code.length, w_code.pattern} = {3'd4, 5'b00100}; // F ..-.
        8'h47:   {w_code.length, w_code.pattern} = {3'd3, 5'b11000}; // G --.
        8'h48:   {w_code.length, w_code.pattern} = {3'd4, 5'b00000}; // H ....
        8'h49:   {w_code.length, w_code.pattern} = {3'd2, 5'b00000}; // I ..
        8'h4A:   {w_code.length, w_code.pattern} = {3'd4, 5'b01110}; // J .---
        8'h4B:   {w_code.length, w_code.pattern} = {3'd3, 5'b10100}; // K -.-
        8'h4C:   {w_code.length, w_code.pattern} = {3'd4, 5'b01000}; // L .-..
        8'h4D:   {w_code.length, w_code.pattern} = {3'd2, 5'b11000}; // M --
        8'h4E:   {w_code.length, w_code.pattern} = {3'd2, 5'b10000}; // N -.
        8'h4F:   {w_code.length, w_code.pattern} = {3'd3, 5'b11100}; // O ---
        8'h50:   {w_code.length, w_code.pattern} = {3'd4, 5'b01100}; // P .--.
        8'h51:   {w_code.length, w_code.pattern} = {3'd4, 5'b11010}; // Q --.-
        8'h52:   {w_code.length, w_code.pattern} = {3'd3, 5'b01000}; // R .-.
        8'h53:   {w_code.length, w_code.pattern} = {3'd3, 5'b00000}; // S ...
        8'h54:   {w_code.length, w_code.pattern} = {3'd1, 5'b10000}; // T -
        8'h55:   {w_code.length, w_code.pattern} = {3'd3, 5'b00100}; // U ..-
        8'h56:   {w_code.length, w_code.pattern} = {3'd4, 5'b00010}; // V ...-
        8'h57:   {w_code.length, w_code.pattern} = {3'd3, 5'b01100}; // W .--
        8'h58:   {w_code.length, w_code.pattern} = {3'd4, 5'b10010}; // X -..-
        8'h59:   {w_code.length, w_code.pattern} = {3'd4, 5'b10110}; // Y -.--
        default: {w_code.length, w_code.pattern} = {3'd4, 5'b11000}; // Z --..
      endcase
`ifdef MORSE_DIGITS_EN
    end else if (w_upper >= c_ascii_digit_0 && w_upper <= c_ascii_digit_9) begin
      w_code.supported = 1'b1;
      w_code.length    = 3'd5;
      case (w_upper)
        8'h30:   w_code.pattern = 5'b11111;
        8'h31:   w_code.pattern = 5'b01111;
        8'h32:   w_code.pattern = 5'b00111;
        8'h33:   w_code.pattern = 5'b00011;
        8'h34:   w_code.pattern = 5'b00001;
        8'h35:   w_code.pattern = 5'b00000;
        8'h36:   w_code.pattern = 5'b10000;
        8'h37:   w_code.pattern = 5'b11000;
        8'h38:   w_code.pattern = 5'b11100;
        default: w_code.pattern = 5'b11110;
      endcase
`else
`endif
    end
  end

  assign o_supported = w_code.supported;
  assign o_is_space  = w_code.is_space;
  assign o_length    = w_code.length;
  assign o_pattern   = w_code.pattern;

endmodule
`default_nettype wire

// File: rtl/morse_encoder.sv
`default_nettype none
// ============================================================================
// Module  : morse_encoder
// Brief   : Keys one ASCII character per request as Morse timing on signal.
//           Digit support is enabled by defining MORSE_DIGITS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = c_unit_cycles_default
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] letter,
  input  logic       valid,
  output logic       ready,
  output logic       signal,
  output logic       done,
  output logic       error
);

  localparam logic [31:0] c_unit_reload = 32'(UNIT_CYCLES - 1);

  logic       w_supported;
  logic       w_is_space;
  logic [2:0] w_length;
  logic [4:0] w_pattern;

  morse_lut u_lut (
    .i_letter    (letter),
    .o_supported (w_supported),
    .o_is_space  (w_is_space),
    .o_length    (w_length),
    .o_pattern   (w_pattern)
  );

  morse_state_e r_state;
  morse_state_e w_state_next;
  logic [31:0]  r_cycle_cnt;
  logic [2:0]   r_units_left;
  logic [2:0]   r_elem_idx;
  logic [2:0]   r_length;
  logic [4:0]   r_pattern;
  logic         r_error;

  logic         w_accept;
  logic         w_unit_end;
  logic         w_phase_end;
  logic         w_load;
  logic [2:0]   w_load_units;
  logic         w_capture;
  logic         w_advance;

  assign w_accept    = valid && (r_state == ST_IDLE);
  assign w_unit_end  = (r_cycle_cnt == 32'd0);
  assign w_phase_end = w_unit_end && (r_units_left == 3'd1);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_units = 3'd0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_supported) begin
          w_capture = 1'b1;
          w_load    = 1'b1;
          if (w_is_space) begin
            w_state_next = ST_GAP;
            w_load_units = c_word_units;
          end else begin
            w_state_next = ST_MARK;
            w_load_units = element_units(w_pattern[4]);
          end
        end
      end
      ST_MARK: begin
        if (w_phase_end) begin
          w_advance = 1'b1;
          w_load    = 1'b1;
          if ((r_elem_idx + 3'd1) < r_length) begin
            w_state_next = ST_SPACE;
            w_load_units = c_space_units;
          end else begin
            w_state_next = ST_GAP;
            w_load_units = c_gap_units;
          end
        end
      end
      ST_SPACE: begin
        // Pattern was shifted at the end of the mark, so bit 4 is the next element.
        if (w_phase_end) begin
          w_state_next = ST_MARK;
          w_load       = 1'b1;
          w_load_units = element_units(r_pattern[4]);
        end
      end
      ST_GAP: begin
        if (w_phase_end) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cycle_cnt  <= 32'd0;
      r_units_left <= 3'd0;
      r_elem_idx   <= 3'd0;
      r_length     <= 3'd0;
      r_pattern    <= 5'd0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_error <= w_accept && !w_supported;

      if (w_load) begin
        r_cycle_cnt  <= c_unit_reload;
        r_units_left <= w_load_units;
      end else if (r_state == ST_IDLE || w_phase_end) begin
        r_cycle_cnt  <= 32'd0;
        r_units_left <= 3'd0;
      end else if (w_unit_end) begin
        r_cycle_cnt  <= c_unit_reload;
        r_units_left <= r_units_left - 3'd1;
      end else begin
        r_cycle_cnt  <= r_cycle_cnt - 32'd1;
      end

      if (w_capture) begin
        r_length   <= w_length;
        r_pattern  <= w_pattern;
        r_elem_idx <= 3'd0;
      end else if (w_advance) begin
        r_pattern  <= {r_pattern[3:0], 1'b0};
        r_elem_idx <= r_elem_idx + 3'd1;
      end
    end
  end

  assign ready  = (r_state == ST_IDLE);
  assign signal = (r_state == ST_MARK);
  assign done   = (r_state == ST_GAP) && w_phase_end;
  assign error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_morse_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_morse_encoder
// Brief   : Directed self-checking bench for morse_encoder, UNIT_CYCLES = 4.
//           Digit expectations follow MORSE_DIGITS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_morse_encoder;

  localparam int unsigned UC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] letter;
  logic       valid;
  logic       ready;
  logic       signal;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  morse_encoder #(.UNIT_CYCLES(UC)) dut (
    .clk    (clk),
    .reset  (reset),
    .letter (letter),
    .valid  (valid),
    .ready  (ready),
    .signal (signal),
    .done   (done),
    .error  (error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Bit k of each capture vector holds the value seen in cycle T+k.
  logic [127:0] cap_sig, cap_done, cap_err, cap_rdy;
  logic [127:0] exp_sig;
  int           exp_pos;

  task automatic exp_clear();
    exp_sig = '0;
    exp_pos = 1;
  endtask

  task automatic exp_seg(input logic lvl, input int len);
    for (int i = 0; i < len; i++) begin
      exp_sig[exp_pos] = lvl;
      exp_pos++;
    end
  endtask

  function automatic logic [127:0] rdy_mask(input int d, input int n);
    logic [127:0] m;
    m = '0;
    for (int k = d + 1; k <= n; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] one_hot(input int k);
    logic [127:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  task automatic accept(input logic [7:0] ch, input bit hold);
    @(negedge clk);
    letter = ch;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic capture(input int n);
    cap_sig = '0; cap_done = '0; cap_err = '0; cap_rdy = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_sig[k]  = signal;
      cap_done[k] = done;
      cap_err[k]  = error;
      cap_rdy[k]  = ready;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b1; letter = 8'h45;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests += 4;
    if (ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    if (signal !== 1'b0) begin n_fail++; $display("FAIL reset_signal: got %b expected 0", signal); end
    if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    if (error !== 1'b0)  begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (signal !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_override_valid: got sig=%b rdy=%b expected sig=0 rdy=1", signal, ready);
    end
  endtask

  task automatic test_letter_e();
    accept(8'h45, 1'b0);
    capture(18);
    exp_clear(); exp_seg(1'b1, 4); exp_seg(1'b0, 14);
    n_tests += 4;
    if (cap_sig !== exp_sig)         begin n_fail++; $display("FAIL E_signal: got %h expected %h", cap_sig, exp_sig); end
    if (cap_done !== one_hot(16))    begin n_fail++; $display("FAIL E_done: got %h expected %h", cap_done, one_hot(16)); end
    if (cap_rdy !== rdy_mask(16, 18)) begin n_fail++; $display("FAIL E_ready: got %h expected %h", cap_rdy, rdy_mask(16, 18)); end
    if (cap_err !== '0)              begin n_fail++; $display("FAIL E_error: got %h expected 0", cap_err); end
  endtask

  task automatic test_lowercase();
    accept(8'h61, 1'b0);
    capture(34);
    exp_clear(); exp_seg(1'b1, 4); exp_seg(1'b0, 4); exp_seg(1'b1, 12); exp_seg(1'b0, 14);
    n_tests += 2;
    if (cap_sig !== exp_sig)      begin n_fail++; $display("FAIL a_signal: got %h expected %h", cap_sig, exp_sig); end
    if (cap_done !== one_hot(32)) begin n_fail++; $display("FAIL a_done: got %h expected %h", cap_done, one_hot(32)); end
    accept(8'h7A, 1'b0);
    capture(58);
    exp_clear();
    exp_seg(1'b1, 12); exp_seg(1'b0, 4); exp_seg(1'b1, 12); exp_seg(1'b0, 4);
    exp_seg(1'b1, 4);  exp_seg(1'b0, 4); exp_seg(1'b1, 4);  exp_seg(1'b0, 14);
    n_tests += 2;
    if (cap_sig !== exp_sig)      begin n_fail++; $display("FAIL z_signal: got %h expected %h", cap_sig, exp_sig); end
    if (cap_done !== one_hot(56)) begin n_fail++; $display("FAIL z_done: got %h expected %h", cap_done, one_hot(56)); end
  endtask

  task automatic test_digit();
    accept(8'h30, 1'b0);
`ifdef MORSE_DIGITS_EN
    capture(90);
    exp_clear();
    for (int i = 0; i < 5; i++) begin
      exp_seg(1'b1, 12);
      if (i < 4) exp_seg(1'b0, 4);
    end
    exp_seg(1'b0, 14);
    n_tests += 3;
    if (cap_sig !== exp_sig)      begin n_fail++; $display("FAIL d0_signal: got %h expected %h", cap_sig, exp_sig); end
    if (cap_done !== one_hot(88)) begin n_fail++; $display("FAIL d0_done: got %h expected %h", cap_done, one_hot(88)); end
    if (cap_err !== '0)           begin n_fail++; $display("FAIL d0_error: got %h expected 0", cap_err); end
`else
    capture(4);
    n_tests += 3;
    if (cap_err !== one_hot(1))     begin n_fail++; $display("FAIL d0_error: got %h expected %h", cap_err, one_hot(1)); end
    if (cap_sig !== '0)             begin n_fail++; $display("FAIL d0_signal: got %h expected 0", cap_sig); end
    if (cap_rdy !== rdy_mask(0, 4)) begin n_fail++; $display("FAIL d0_ready: got %h expected %h", cap_rdy, rdy_mask(0, 4)); end
`endif
  endtask

  task automatic test_space();
    accept(8'h20, 1'b0);
    capture(18);
    n_tests += 3;
    if (cap_sig !== '0)               begin n_fail++; $display("FAIL space_signal: got %h expected 0", cap_sig); end
    if (cap_done !== one_hot(16))     begin n_fail++; $display("FAIL space_done: got %h expected %h", cap_done, one_hot(16)); end
    if (cap_rdy !== rdy_mask(16, 18)) begin n_fail++; $display("FAIL space_ready: got %h expected %h", cap_rdy, rdy_mask(16, 18)); end
  endtask

  task automatic test_unsupported();
    logic [7:0] codes [5];
    codes = '{8'h7E, 8'h40, 8'h5B, 8'h60, 8'h7B};
    for (int i = 0; i < 5; i++) begin
      accept(codes[i], 1'b0);
      capture(4);
      n_tests += 3;
      if (cap_err !== one_hot(1))     begin n_fail++; $display("FAIL unsup_%h_error: got %h expected %h", codes[i], cap_err, one_hot(1)); end
      if (cap_sig !== '0)             begin n_fail++; $display("FAIL unsup_%h_signal: got %h expected 0", codes[i], cap_sig); end
      if (cap_rdy !== rdy_mask(0, 4)) begin n_fail++; $display("FAIL unsup_%h_ready: got %h expected %h", codes[i], cap_rdy, rdy_mask(0, 4)); end
    end
  endtask

  task automatic test_reset_mid();
    accept(8'h54, 1'b0);
    @(negedge clk);
    n_tests++;
    if (signal !== 1'b1) begin n_fail++; $display("FAIL T_mark_start: got %b expected 1", signal); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests += 3;
    if (signal !== 1'b0) begin n_fail++; $display("FAIL midrst_signal: got %b expected 0", signal); end
    if (ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    if (done !== 1'b0)   begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    reset = 1'b0;
    capture(20);
    n_tests += 2;
    if (cap_done !== '0) begin n_fail++; $display("FAIL midrst_no_done: got %h expected 0", cap_done); end
    if (cap_sig !== '0)  begin n_fail++; $display("FAIL midrst_quiet: got %h expected 0", cap_sig); end
  endtask

  task automatic test_back_to_back();
    // Valid stays high throughout; letter changes while busy and must be ignored.
    accept(8'h4E, 1'b1);
    letter = 8'h45;
    capture(34);
    exp_clear();
    exp_seg(1'b1, 12); exp_seg(1'b0, 4); exp_seg(1'b1, 4); exp_seg(1'b0, 13); exp_seg(1'b1, 1);
    n_tests += 3;
    if (cap_sig !== exp_sig)          begin n_fail++; $display("FAIL b2b_N_signal: got %h expected %h", cap_sig, exp_sig); end
    if (cap_done !== one_hot(32))     begin n_fail++; $display("FAIL b2b_N_done: got %h expected %h", cap_done, one_hot(32)); end
    if (cap_rdy !== one_hot(33))      begin n_fail++; $display("FAIL b2b_N_ready: got %h expected %h", cap_rdy, one_hot(33)); end
    valid = 1'b0;
    capture(18);
    exp_clear(); exp_seg(1'b1, 3); exp_seg(1'b0, 15);
    n_tests += 2;
    if (cap_sig !== exp_sig)      begin n_fail++; $display("FAIL b2b_E_signal: got %h expected %h", cap_sig, exp_sig); end
    if (cap_done !== one_hot(15)) begin n_fail++; $display("FAIL b2b_E_done: got %h expected %h", cap_done, one_hot(15)); end
  endtask

  initial begin
    reset  = 1'b1;
    valid  = 1'b0;
    letter = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_letter_e();
    test_lowercase();
    test_digit();
    test_space();
    test_unsupported();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 25_000_000, clk cycles per Morse time unit (200 ms at 125 MHz); legal range 2..2^32-1.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port letter  input  8  ASCII character to transmit; sampled only on accept.
REQ-005 SHALL have port valid  input  1  request; accept occurs on a cycle with valid && ready.
REQ-006 SHALL have port ready  output  1  high only in IDLE.
REQ-007 SHALL have port signal  output  1  keyed Morse output (1 = mark); drives LED/Pmod.
REQ-008 SHALL have port done  output  1  one-cycle pulse on the final cycle of a character.
REQ-009 SHALL have port error  output  1  one-cycle pulse when an unsupported character is accepted.

Function
REQ-010 SHALL support A-Z (0x41-0x5A), a-z (0x61-0x7A, folded to uppercase), space (0x20), and digits per REQ-024; all other codes are unsupported.
REQ-011 SHALL map each letter to a length (1..5) and a 5-bit pattern, sent MSB-first, with 1 = dash and 0 = dot (ITU table).
REQ-012 SHALL implement states IDLE, MARK, SPACE, GAP.
REQ-013 IDLE: on accept of a supported non-space character, SHALL go to MARK next cycle; signal rises the cycle after accept.
REQ-014 MARK SHALL hold signal=1 for 1 unit (dot) or 3 units (dash), then enter SPACE if elements remain, else GAP.
REQ-015 SPACE SHALL hold signal=0 for 1 unit, then enter MARK for the next element.
REQ-016 GAP SHALL hold signal=0 for 3 units after the last element; space (0x20) SHALL enter GAP directly for 4 units, giving a 7-unit word gap after a preceding letter.
REQ-017 SHALL assert done on the last cycle of GAP; SHALL return to IDLE the next cycle, with ready high.
REQ-018 Unsupported character accept SHALL pulse error on the cycle after accept, leave signal low, and remain in IDLE.
REQ-019 SHALL ignore valid while not ready; there is no queueing and letter is not resampled.
REQ-020 SHALL implement a unit counter of 32 bits, reloaded at each state entry and never wrapping within an element; the element index SHALL be 3 bits.

Reset
REQ-021 On reset, the next edge SHALL give state=IDLE, signal=0, done=0, error=0, ready=1, counters=0.
REQ-022 Reset mid-character SHALL abort without a done pulse; reset SHALL override a simultaneous valid.

Configuration
REQ-023 Macro MORSE_DIGITS_EN SHALL control digit support.
REQ-024 With MORSE_DIGITS_EN defined, 0x30-0x39 SHALL encode as five-element ITU digits; without it, digits SHALL be unsupported per REQ-018.

Structure
REQ-025 Package morse_pkg SHALL hold the state encoding, ASCII range constants, dot/dash/gap unit counts (1, 3, 1, 3, 4), and the UNIT_CYCLES default.
REQ-026 Sub-module morse_lut SHALL provide a combinational mapping letter -> {supported, is_space, length[2:0], pattern[4:0]}, reusable by the decoder.

Verification (UNIT_CYCLES=4, accept at cycle T)
REQ-027 Sending 'E' (0x45) SHALL give signal=1 for T+1..T+4, signal=0 for T+5..T+16, done at T+16, and ready at T+17.
REQ-028 Sending 'a' (0x61) SHALL give signal high 4 cycles, low 4, high 12, low 12, with done at T+32.
REQ-029 Sending '0' (0x30) with MORSE_DIGITS_EN SHALL give 5 marks of 12 cycles separated by 4-cycle spaces, with done at T+88; without the macro, it SHALL give error at T+1, signal low, and ready held.
REQ-030 Sending 0x20 SHALL hold signal=0 for 16 cycles, with done at T+16; sending 0x7E SHALL pulse error only.
REQ-031 Reset at T+2 during 'T' (0x54) SHALL give signal=0 and ready=1 at T+3 with no done; valid held high while busy SHALL not alter the output sequence.
